// File: rtl/bus_arb_pkg.sv
// Shared types and phase constants for the VIC-II / 6510 bus access arbiter.
// All phase landmarks derive from PHASES so the counter width and decode stay consistent.
package bus_arb_pkg;

  localparam int PHASES  = 32;
  localparam int PHASE_W = $clog2(PHASES);
  localparam int GUARD   = 1;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t     PHASE_LAST     = phase_t'(PHASES - 1);
  localparam phase_t     PHI1_LAST      = phase_t'(PHASES / 2 - 1);
  localparam phase_t     PHI2_FIRST     = phase_t'(PHASES / 2);
  localparam phase_t     DB_DRIVE_START = phase_t'(PHASES / 2 + 2);
  localparam logic [1:0] BA_LEAD        = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    BA_WAIT,
    STEAL
  } arb_state_t;

endpackage

// File: rtl/phi_phase_gen.sv
// Free-running tick counter within the phi cycle plus the registered clk_phi.
// Exposes next_phase so downstream registers can decode the tick they are about to enter.
module phi_phase_gen
  import bus_arb_pkg::*;
(
  input  logic               clk_dot4x,
  input  logic               rst_n,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] next_phase,
  output logic               clk_phi,
  output logic               sample
);

  // The last tick of a phi cycle is both the steal_req sample point and the boundary.
  assign sample     = (phase == PHASE_LAST);
  assign next_phase = sample ? '0 : phase + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      clk_phi <= 1'b0;
    end else begin
      phase   <= next_phase;
      clk_phi <= (next_phase >= PHI2_FIRST);
    end
  end

endmodule

// File: rtl/bus_access_arbiter.sv
// Shares the C64 bus between VIC-II and 6510: phi generation, BA lead-in, AEC and drive enables.
// Optional BUS_TURNAROUND_EN adds a GUARD-tick gap around every address-bus handover.
module bus_access_arbiter
  import bus_arb_pkg::*;
(
  input  logic               clk_dot4x,
  input  logic               rst_n,
  input  logic               steal_req,
  input  logic               ce,
  input  logic               rw,
  output logic               clk_phi,
  output logic [PHASE_W-1:0] phase,
  output logic               ba,
  output logic               aec,
  output logic               stealing,
  output logic               vic_write_ab,
  output logic               vic_write_db,
  output logic               ls245_data_dir
);

  logic [PHASE_W-1:0] next_phase;
  logic               sample;
  arb_state_t         state, state_next;
  logic [1:0]         lead_cnt, lead_cnt_next;
  logic               ba_next, aec_next, stealing_next, ab_next, db_next;
  logic               guard_block;

  phi_phase_gen u_phase (
    .clk_dot4x  (clk_dot4x),
    .rst_n      (rst_n),
    .phase      (phase),
    .next_phase (next_phase),
    .clk_phi    (clk_phi),
    .sample     (sample)
  );

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lead_cnt <= '0;
    end else begin
      state    <= state_next;
      lead_cnt <= lead_cnt_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    lead_cnt_next = lead_cnt;
    if (sample) begin
      unique case (state)
        IDLE: begin
          if (steal_req) begin
            state_next    = BA_WAIT;
            lead_cnt_next = 2'd1;
          end
        end
        BA_WAIT: begin
          if (!steal_req)               state_next    = IDLE;
          else if (lead_cnt == BA_LEAD) state_next    = STEAL;
          else                          lead_cnt_next = lead_cnt + 2'd1;
        end
        STEAL: begin
          if (!steal_req) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state and tick being entered, then registered.
  always_comb begin
    ba_next       = (state_next == IDLE);
    stealing_next = (state_next == STEAL);
    aec_next      = !stealing_next && (next_phase >= PHI2_FIRST);
    db_next       = !ce && rw && aec_next && !stealing_next && (next_phase >= DB_DRIVE_START);
    ab_next       = !aec_next && !guard_block;
  end

`ifdef BUS_TURNAROUND_EN
  localparam phase_t RISE_GUARD_START = phase_t'(PHASES / 2 - GUARD);

  logic [1:0] hold_cnt;
  logic       aec_falling;

  assign aec_falling = aec && !aec_next;

  // A rise at phi2 is predictable whenever the next cycle is not stolen; a fall is seen as it happens.
  assign guard_block = aec_falling || (hold_cnt != 2'd0) ||
                       (!stealing_next && (next_phase >= RISE_GUARD_START) &&
                        (next_phase <= PHI1_LAST));

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n)                 hold_cnt <= 2'd0;
    else if (aec_falling)       hold_cnt <= 2'(GUARD - 1);
    else if (hold_cnt != 2'd0)  hold_cnt <= hold_cnt - 2'd1;
  end
`else
  assign guard_block = 1'b0;
`endif

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      ba           <= 1'b1;
      aec          <= 1'b0;
      stealing     <= 1'b0;
      vic_write_ab <= 1'b0;
      vic_write_db <= 1'b0;
    end else begin
      ba           <= ba_next;
      aec          <= aec_next;
      stealing     <= stealing_next;
      vic_write_ab <= ab_next;
      vic_write_db <= db_next;
    end
  end

  assign ls245_data_dir = vic_write_db;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Randomized and directed bench for bus_access_arbiter against a run-length reference model.
// The model counts consecutive high steal_req samples per phi cycle and derives ownership from that.
module tb_bus_access_arbiter;

  localparam int PHASES  = 32;
  localparam int HALF    = PHASES / 2;
  localparam int LEAD    = 3;
  localparam int GUARD_T = 1;

  logic       clk_dot4x = 1'b0;
  logic       rst_n;
  logic       steal_req, ce, rw;
  logic       clk_phi, ba, aec, stealing, vic_write_ab, vic_write_db, ls245_data_dir;
  logic [4:0] phase;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_phase, m_run, m_since_fall;
  bit e_clk_phi, e_ba, e_aec, e_steal, e_ab, e_db;
  int steal_ticks, ba_low_ticks, db_ticks;

  bus_access_arbiter dut (
    .clk_dot4x      (clk_dot4x),
    .rst_n          (rst_n),
    .steal_req      (steal_req),
    .ce             (ce),
    .rw             (rw),
    .clk_phi        (clk_phi),
    .phase          (phase),
    .ba             (ba),
    .aec            (aec),
    .stealing       (stealing),
    .vic_write_ab   (vic_write_ab),
    .vic_write_db   (vic_write_db),
    .ls245_data_dir (ls245_data_dir)
  );

  initial forever #5 clk_dot4x = ~clk_dot4x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic reset_model();
    m_phase      = 0;
    m_run        = 0;
    m_since_fall = GUARD_T;
    e_clk_phi    = 0;
    e_ba         = 1;
    e_aec        = 0;
    e_steal      = 0;
    e_ab         = 0;
    e_db         = 0;
  endtask

  // One dot4x tick: sample steal_req on the last tick, advance, derive outputs.
  task automatic model_step();
    bit prev_aec;
    bit blocked;
    prev_aec = e_aec;
    if (m_phase == PHASES - 1) m_run = steal_req ? ((m_run < 100) ? m_run + 1 : m_run) : 0;
    m_phase   = (m_phase + 1) % PHASES;
    e_ba      = (m_run == 0);
    e_steal   = (m_run > LEAD);
    e_clk_phi = (m_phase >= HALF);
    e_aec     = !e_steal && e_clk_phi;
    e_db      = !ce && rw && e_aec && (m_phase >= HALF + 2);
    blocked   = 0;
`ifdef BUS_TURNAROUND_EN
    if (prev_aec && !e_aec) m_since_fall = 0;
    else if (m_since_fall < GUARD_T) m_since_fall++;
    blocked = (m_since_fall < GUARD_T) ||
              (!e_steal && m_phase >= HALF - GUARD_T && m_phase < HALF);
`else
    m_since_fall = prev_aec ? GUARD_T : GUARD_T;
`endif
    e_ab = !e_aec && !blocked;
  endtask

  task automatic check_outputs();
    check("phase", 32'(phase), 32'(m_phase));
    check("clk_phi", 32'(clk_phi), 32'(e_clk_phi));
    check("ba", 32'(ba), 32'(e_ba));
    check("aec", 32'(aec), 32'(e_aec));
    check("stealing", 32'(stealing), 32'(e_steal));
    check("vic_write_ab", 32'(vic_write_ab), 32'(e_ab));
    check("vic_write_db", 32'(vic_write_db), 32'(e_db));
    check("ls245_data_dir", 32'(ls245_data_dir), 32'(e_db));
  endtask

  task automatic step();
    @(posedge clk_dot4x);
    model_step();
    @(negedge clk_dot4x);
    check_outputs();
    if (stealing)     steal_ticks++;
    if (!ba)          ba_low_ticks++;
    if (vic_write_db) db_ticks++;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    steal_ticks  = 0;
    ba_low_ticks = 0;
    db_ticks     = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    steal_req = 1'b0;
    ce        = 1'b1;
    rw        = 1'b1;
    reset_model();
    clear_counts();
    repeat (2) @(negedge clk_dot4x);
    check_outputs();
    rst_n = 1'b1;

    // idle cycles; afterwards phase is 0, the start of "cycle 0"
    run_ticks(3 * PHASES);
    check("idle_ba_low", 32'(ba_low_ticks), 32'd0);

    // steal_req rises at cycle 0 phase 10, dropped at cycle 6 phase 20
    clear_counts();
    run_ticks(10);
    steal_req = 1'b1;
    run_ticks(6 * PHASES + 20 - 10);
    steal_req = 1'b0;
    run_ticks(8 * PHASES - (6 * PHASES + 20));
    check("steal_len", 32'(steal_ticks), 32'(3 * PHASES));
    check("steal_ba_low", 32'(ba_low_ticks), 32'(6 * PHASES));

    // one sampled-high pulse: BA low for exactly one phi cycle, no steal
    clear_counts();
    run_ticks(5);
    steal_req = 1'b1;
    run_ticks(PHASES);
    steal_req = 1'b0;
    run_ticks(3 * PHASES - 5);
    check("pulse_ba_low", 32'(ba_low_ticks), 32'(PHASES));
    check("pulse_steal", 32'(steal_ticks), 32'd0);

    // steal_req high away from the sample tick is ignored
    clear_counts();
    run_ticks(10);
    steal_req = 1'b1;
    run_ticks(10);
    steal_req = 1'b0;
    run_ticks(2 * PHASES - 20);
    check("glitch_ba_low", 32'(ba_low_ticks), 32'd0);

    // CPU register read with no steal: phases 18..31 of each cycle
    clear_counts();
    ce = 1'b0;
    rw = 1'b1;
    run_ticks(2 * PHASES);
    check("db_ticks", 32'(db_ticks), 32'(2 * (PHASES - HALF - 2)));

    // same read held through a full steal sequence
    steal_req = 1'b1;
    run_ticks(5 * PHASES);
    clear_counts();
    run_ticks(PHASES);
    check("db_in_steal", 32'(db_ticks), 32'd0);
    check("steal_full", 32'(steal_ticks), 32'(PHASES));
    steal_req = 1'b0;
    ce        = 1'b1;
    run_ticks(2 * PHASES);

    // random traffic
    for (int i = 0; i < 2400; i++) begin
      if ($urandom_range(0, 47) == 0) steal_req = ~steal_req;
      if ($urandom_range(0, 3) == 0)  ce = ~ce;
      rw = 1'($urandom_range(0, 1));
      step();
    end

    // asynchronous reset while stealing
    steal_req = 1'b1;
    ce        = 1'b0;
    rw        = 1'b1;
    run_ticks(6 * PHASES + 7);
    check("pre_reset_steal", 32'(stealing), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ba", 32'(ba), 32'd1);
    check("arst_aec", 32'(aec), 32'd0);
    check("arst_stealing", 32'(stealing), 32'd0);
    check("arst_ab", 32'(vic_write_ab), 32'd0);
    check("arst_db", 32'(vic_write_db), 32'd0);
    check("arst_dir", 32'(ls245_data_dir), 32'd0);
    check("arst_phase", 32'(phase), 32'd0);
    reset_model();
    @(negedge clk_dot4x);
    check_outputs();
    steal_req = 1'b0;
    rst_n     = 1'b1;
    run_ticks(4 * PHASES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
